// File: rtl/clock_pkg.sv
// Shared definitions for the clock driver/receiver pair: state encoding
// and default counter widths.
package clock_pkg;

  localparam int COUNTER_BITS_DEFAULT = 28;
  localparam int STRETCH_BITS_DEFAULT = 20;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_HIGH   = 2'd1,
    ST_HALTED = 2'd2
  } clock_state_t;

endpackage

// File: rtl/period_meter.sv
// Measures the number of i_clk cycles between consecutive i_event pulses,
// saturating at all-ones.
module period_meter
  import clock_pkg::*;
#(
  parameter int COUNTER_BITS = COUNTER_BITS_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_event,
  output logic [COUNTER_BITS-1:0] o_period,
  output logic                    o_valid
);

  logic [COUNTER_BITS-1:0] count;
  logic [COUNTER_BITS-1:0] count_inc;
  logic                    seen_first;

  assign count_inc = (count == '1) ? count : count + 1'b1;

  // A period is only meaningful once two events bound it, hence seen_first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count      <= '0;
      o_period   <= '0;
      seen_first <= 1'b0;
      o_valid    <= 1'b0;
    end else if (i_event) begin
      o_period   <= count_inc;
      count      <= '0;
      seen_first <= 1'b1;
      if (seen_first) o_valid <= 1'b1;
    end else begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/clock_receiver.sv
// Turns clock-enable pulses into a logical clock with rise/fall strobes,
// honours CPU halt/resume, measures the enable period and drives an LED.
module clock_receiver
  import clock_pkg::*;
#(
  parameter int COUNTER_BITS = COUNTER_BITS_DEFAULT,
  parameter int STRETCH_BITS = STRETCH_BITS_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic                    i_halt,
  input  logic                    i_resume,
  output logic                    o_rise,
  output logic                    o_fall,
  output logic                    o_phase,
  output logic                    o_halted,
  output logic [COUNTER_BITS-1:0] o_period,
  output logic                    o_period_valid,
  output logic                    o_led
);

  clock_state_t            state;
  clock_state_t            next_state;
  logic                    rise_next;
  logic                    fall_next;
  logic [STRETCH_BITS-1:0] stretch;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_LOW;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      state  <= next_state;
      o_rise <= rise_next;
      o_fall <= fall_next;
    end
  end

  // A high phase always completes; halt is only honoured at a rising edge.
  always_comb begin
    next_state = state;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state)
      ST_LOW: begin
        if (i_enable) begin
          if (i_halt) begin
            next_state = ST_HALTED;
          end else begin
            next_state = ST_HIGH;
            rise_next  = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (i_enable) begin
          next_state = ST_LOW;
          fall_next  = 1'b1;
        end
      end
      ST_HALTED: begin
        if (i_resume) next_state = ST_LOW;
      end
      default: next_state = ST_LOW;
    endcase
  end

  assign o_phase  = (state == ST_HIGH);
  assign o_halted = (state == ST_HALTED);

  // Stretch keeps very short high phases visible on the LED.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stretch <= '0;
    end else if (o_rise) begin
      stretch <= '1;
    end else if (stretch != '0) begin
      stretch <= stretch - 1'b1;
    end
  end

  assign o_led = o_phase | (|stretch);

  period_meter #(
    .COUNTER_BITS(COUNTER_BITS)
  ) u_period_meter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_event (i_enable),
    .o_period(o_period),
    .o_valid (o_period_valid)
  );

endmodule

// File: tb/tb_clock_receiver.sv
// Self-checking bench for clock_receiver: timestamp-based reference model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_clock_receiver;

  localparam int CB = 8;
  localparam int SB = 4;
  localparam int PERIOD_MAX = (1 << CB) - 1;
  localparam int STRETCH_LEN = (1 << SB) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          halt = 1'b0;
  logic          resume = 1'b0;
  logic          rise, fall, phase, halted, period_valid, led;
  logic [CB-1:0] period;

  int errors = 0;
  int checks = 0;
  bit compare_on = 1'b0;

  clock_receiver #(
    .COUNTER_BITS(CB),
    .STRETCH_BITS(SB)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (enable),
    .i_halt        (halt),
    .i_resume      (resume),
    .o_rise        (rise),
    .o_fall        (fall),
    .o_phase       (phase),
    .o_halted      (halted),
    .o_period      (period),
    .o_period_valid(period_valid),
    .o_led         (led)
  );

  always #5 clk = ~clk;

  // Reference model: edges are numbered, the period is the distance in edges
  // since the last enable (or since reset), the LED window is timed from
  // the edge at which the rise strobe appeared.
  int  cyc = 0;
  int  anchor = 0;
  int  enables_seen = 0;
  int  rise_edge = 0;
  bit  rise_seen = 1'b0;
  bit  m_phase = 1'b0, m_halted = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  int  m_period = 0;
  bit  m_valid = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_halted = 0; m_rise = 0; m_fall = 0;
      m_period = 0; m_valid = 0; enables_seen = 0;
      rise_seen = 0; anchor = cyc;
    end else begin
      cyc++;
      m_rise = 0;
      m_fall = 0;
      if (enable) begin
        m_period = (cyc - anchor > PERIOD_MAX) ? PERIOD_MAX : cyc - anchor;
        anchor = cyc;
        enables_seen++;
        if (enables_seen >= 2) m_valid = 1;
      end
      if (m_halted) begin
        if (resume) m_halted = 0;
      end else if (enable) begin
        if (m_phase) begin
          m_phase = 0;
          m_fall = 1;
        end else if (halt) begin
          m_halted = 1;
        end else begin
          m_phase = 1;
          m_rise = 1;
          rise_edge = cyc;
          rise_seen = 1;
        end
      end
    end
  end

  function automatic bit model_led();
    return m_phase || (rise_seen && (cyc - rise_edge >= 1) && (cyc - rise_edge <= STRETCH_LEN));
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Every cycle, away from the active edge, compare against the model.
  always @(negedge clk) begin
    if (compare_on) begin
      checkOutput("rise", rise, m_rise);
      checkOutput("fall", fall, m_fall);
      checkOutput("phase", phase, m_phase);
      checkOutput("halted", halted, m_halted);
      checkOutput("period", period, m_period);
      checkOutput("period_valid", period_valid, m_valid);
      checkOutput("led", led, model_led());
      checkOutput("rise_fall_exclusive", rise & fall, 0);
    end
  end

  // Drive one cycle of inputs, then return just after the edge sampling them.
  task automatic applyStimulus(input bit en, input bit hl, input bit rs, input int n = 1);
    for (int i = 0; i < n; i++) begin
      enable = en;
      halt   = hl;
      resume = rs;
      @(posedge clk);
      #1;
    end
    enable = 0;
    resume = 0;
  endtask

  task automatic idle(input bit hl, input int n);
    if (n > 0) applyStimulus(1'b0, hl, 1'b0, n);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    compare_on = 1'b1;
    checkOutput("reset_period", period, 0);
    checkOutput("reset_led", led, 0);
    rst_n = 1'b1;
    idle(0, 2);

    // Enables every 10 cycles
    applyStimulus(1, 0, 0);
    checkOutput("s1_first_rise", rise, 1);
    checkOutput("s1_first_valid", period_valid, 0);
    idle(0, 9);
    applyStimulus(1, 0, 0);
    checkOutput("s1_fall", fall, 1);
    checkOutput("s1_period10", period, 10);
    checkOutput("s1_valid", period_valid, 1);
    idle(0, 9);
    applyStimulus(1, 0, 0);
    checkOutput("s1_rise2", rise, 1);

    // Halt raised while HIGH: next enable falls, following one halts
    idle(1, 5);
    applyStimulus(1, 1, 0);
    checkOutput("s2_fall", fall, 1);
    checkOutput("s2_not_halted", halted, 0);
    idle(1, 4);
    applyStimulus(1, 1, 0);
    checkOutput("s2_halted", halted, 1);
    checkOutput("s2_no_rise", rise, 0);

    // In HALTED: enables ignored, resume with enable returns to LOW
    for (int k = 0; k < 3; k++) begin
      idle(1, 3);
      applyStimulus(1, 1, 0);
    end
    checkOutput("s3_still_halted", halted, 1);
    checkOutput("s3_period4", period, 4);
    idle(1, 3);
    applyStimulus(1, 0, 1);
    checkOutput("s3_resumed", halted, 0);
    checkOutput("s3_phase_low", phase, 0);
    checkOutput("s3_no_rise", rise, 0);
    idle(0, 2);
    applyStimulus(1, 0, 0);
    checkOutput("s3_rise", rise, 1);
    checkOutput("s3_period3", period, 3);

    // Enable held for 4 cycles from LOW
    applyStimulus(1, 0, 0);
    idle(0, 20);
    applyStimulus(1, 0, 0);
    checkOutput("s4_rise_a", rise, 1);
    applyStimulus(1, 0, 0);
    checkOutput("s4_fall_a", fall, 1);
    checkOutput("s4_period1", period, 1);
    applyStimulus(1, 0, 0);
    checkOutput("s4_rise_b", rise, 1);
    applyStimulus(1, 0, 0);
    checkOutput("s4_fall_b", fall, 1);

    // Single short high phase: LED stretched for 15 cycles after the rise
    idle(0, 20);
    applyStimulus(1, 0, 0);
    checkOutput("s5_rise", rise, 1);
    applyStimulus(1, 0, 0);
    checkOutput("s5_led_r1", led, 1);
    for (int k = 2; k <= 15; k++) begin
      idle(0, 1);
      checkOutput("s5_led_on", led, 1);
    end
    idle(0, 1);
    checkOutput("s5_led_off", led, 0);

    // Reset mid-HIGH, long idle, saturated period
    applyStimulus(1, 0, 0);
    checkOutput("s6_high", phase, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("s6_rst_phase", phase, 0);
    checkOutput("s6_rst_led", led, 0);
    checkOutput("s6_rst_period", period, 0);
    checkOutput("s6_rst_valid", period_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(0, (1 << CB) + 5);
    checkOutput("s6_no_strobe", rise | fall, 0);
    applyStimulus(1, 0, 0);
    checkOutput("s6_rise", rise, 1);
    checkOutput("s6_period_sat", period, 255);
    checkOutput("s6_valid_low", period_valid, 0);
    idle(0, 5);
    applyStimulus(1, 0, 0);
    checkOutput("s6_fall", fall, 1);
    checkOutput("s6_period6", period, 6);
    checkOutput("s6_valid_high", period_valid, 1);

    idle(0, 3);
    compare_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_receiver.md
CLOCK_RECEIVER -- requirements
Module: clock_receiver

Interface
REQ-001 Parameter COUNTER_BITS, default 28, width of the enable-period measurement.
REQ-002 Parameter STRETCH_BITS, default 20, width of the LED pulse-stretch counter.
REQ-003 i_clk  input  1  system clock; all logic on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_enable  input  1  single-cycle clock-enable pulse from the clock driver; each pulse is one logical clock edge.
REQ-006 i_halt  input  1  CPU HLT level.
REQ-007 i_resume  input  1  debounced single-cycle pulse that releases a halt.
REQ-008 o_rise  output  1  single-cycle strobe marking the logical-clock rising edge.
REQ-009 o_fall  output  1  single-cycle strobe marking the logical-clock falling edge.
REQ-010 o_phase  output  1  logical clock level.
REQ-011 o_halted  output  1  high while in HALTED.
REQ-012 o_period  output  COUNTER_BITS  i_clk cycles between the last two i_enable pulses.
REQ-013 o_period_valid  output  1  high once o_period holds a real measurement.
REQ-014 o_led  output  1  visible clock indicator.

Function
REQ-015 States: LOW, HIGH, HALTED; o_phase SHALL be 1 only in HIGH.
REQ-016 LOW with i_enable=1 and i_halt=0 SHALL go to HIGH, with o_rise=1 for exactly the next cycle.
REQ-017 LOW with i_enable=1 and i_halt=1 SHALL go to HALTED, with no o_rise.
REQ-018 HIGH with i_enable=1 SHALL go to LOW, with o_fall=1 for exactly the next cycle, regardless of i_halt; a high phase is never truncated.
REQ-019 HALTED SHALL ignore i_enable; i_resume=1 SHALL go to LOW with no strobe, and an i_enable in the same cycle is discarded.
REQ-020 i_resume outside HALTED SHALL be ignored.
REQ-021 i_halt with no i_enable SHALL cause no transition.
REQ-022 Registered outputs: o_rise, o_fall, o_phase and o_halted SHALL change exactly one i_clk cycle after the qualifying input cycle.
REQ-023 o_rise and o_fall SHALL never both be 1 in the same cycle.
REQ-024 Period counter: increments every cycle, saturating at all-ones.
REQ-025 On every i_enable (including in HALTED), the period counter SHALL load o_period with count+1 (saturating) and restart at 0, in the same cycle as the corresponding strobe.
REQ-026 i_enable pulses on adjacent cycles SHALL yield o_period=1.
REQ-027 o_period_valid SHALL rise on the second i_enable after reset and stay high until reset.
REQ-028 o_led SHALL be o_phase OR (stretch counter nonzero).
REQ-029 The stretch counter SHALL load all-ones on each o_rise, otherwise decrement to 0 and hold there, so fast clocks remain visible.

Reset
REQ-030 While i_rst_n=0: state LOW; o_rise, o_fall, o_phase, o_halted, o_led, o_period_valid = 0; o_period = 0; period and stretch counters = 0.
REQ-031 Reset asserted mid-HIGH or mid-HALTED SHALL force LOW immediately, with no strobe on deassertion.
REQ-032 The first i_enable after reset deassertion SHALL be processed normally.

Structure
REQ-033 Shared package clock_pkg SHALL hold the state encoding (LOW=0, HIGH=1, HALTED=2, 2 bits) and the COUNTER_BITS/STRETCH_BITS defaults, shared with clock_driver.
REQ-034 Period measurement SHALL be a sub-module period_meter (i_clk, i_rst_n, i_event, o_period, o_valid); the state machine and LED stretch stay in clock_receiver.

Verification (STRETCH_BITS=4 in bench)
REQ-035 Scenario: i_enable pulses every 10 cycles, i_halt=0 -> o_rise and o_fall alternate, first strobe o_rise 1 cycle after the first enable; o_period=10 and o_period_valid=1 after the 2nd enable.
REQ-036 Scenario: i_halt=1 asserted while HIGH, then enable, enable -> o_fall on the 1st enable; HALTED on the 2nd with no o_rise; o_halted=1.
REQ-037 Scenario: in HALTED, 3 enables then i_resume together with an enable -> no strobes, LOW; the next enable (i_halt=0) gives o_rise; o_period still tracks all enables.
REQ-038 Scenario: i_enable held high 4 cycles -> o_rise, o_fall, o_rise, o_fall on consecutive cycles; o_period=1.
REQ-039 Scenario: single o_rise then fall 1 cycle later -> o_led stays high 15 cycles after o_rise, then 0.
REQ-040 Scenario: i_rst_n pulsed low mid-HIGH, no enables for 2^COUNTER_BITS+5 cycles (bench COUNTER_BITS=8) -> all outputs 0 during reset; o_period saturates at 255 on the next enable; o_period_valid=0 until the second post-reset enable.
